// File: rtl/led_matrix_scanner.sv
// Row-multiplexed 8x8 LED matrix driver with a double-buffered bitmap and blanked row changes.
// Optional: define LED_MATRIX_DIMMER_EN to add a 3-bit brightness input that shortens each row's on-time.
module led_matrix_scanner #(
  parameter int CLOCK_HZ       = 27000000,
  parameter int ROW_HZ         = 8000,
  parameter int BLANK_CYCLES   = 16,
  parameter bit ROW_ACTIVE_LOW = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [2:0] wr_row,
  input  logic [7:0] wr_data,
  input  logic       swap_req,
  output logic       swap_done,
  output logic       frame_start,
`ifdef LED_MATRIX_DIMMER_EN
  input  logic [2:0] brightness,
`endif
  output logic [7:0] row,
  output logic [7:0] d
);

  localparam int PERIOD    = CLOCK_HZ / ROW_HZ;
  localparam int CW        = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int DRIVE_LEN = PERIOD - BLANK_CYCLES;
  localparam logic [CW-1:0] LAST_CNT   = CW'(PERIOD - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [7:0]    ROW_IDLE   = ROW_ACTIVE_LOW ? 8'hFF : 8'h00;

  typedef enum logic {BLANK, DRIVE} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    row_n, d_n;
  logic          boundary;
  logic          front_sel;
  logic          swap_pending;
  logic [7:0]    bank [0:1][0:7];
  logic          dim_on;

  assign wr_ready = !swap_pending;

`ifdef LED_MATRIX_DIMMER_EN
  logic [2:0]  bright_q;
  logic [31:0] dim_limit;
  logic [31:0] drive_count;

  always_comb begin
    dim_limit   = ((32'(bright_q) + 32'd1) * 32'(DRIVE_LEN)) >> 3;
    drive_count = 32'(cnt) - 32'(BLANK_CYCLES);
    dim_on      = drive_count < dim_limit;
  end

  // Brightness is frozen for a whole row so the on-window never changes mid-row.
  always_ff @(posedge clock) begin
    if (reset)
      bright_q <= 3'd7;
    else if (state == BLANK && cnt == BLANK_LAST)
      bright_q <= brightness;
  end
`else
  assign dim_on = 1'b1;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= BLANK;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
    end
  end

  // The scan registers name the position the outputs will show after the next edge.
  always_comb begin
    state_n  = state;
    idx_n    = idx;
    cnt_n    = (cnt == LAST_CNT) ? '0 : cnt + CW'(1);
    row_n    = ROW_IDLE;
    d_n      = 8'h00;
    boundary = 1'b0;
    case (state)
      BLANK: begin
        boundary = (cnt == '0) && (idx == 3'd0);
        if (cnt == BLANK_LAST)
          state_n = DRIVE;
      end
      DRIVE: begin
        row_n = ROW_ACTIVE_LOW ? ~(8'h01 << idx) : (8'h01 << idx);
        if (dim_on)
          d_n = bank[front_sel][idx];
        if (cnt == LAST_CNT) begin
          state_n = BLANK;
          idx_n   = idx + 3'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      row          <= ROW_IDLE;
      d            <= 8'h00;
      frame_start  <= 1'b0;
      swap_done    <= 1'b0;
      front_sel    <= 1'b0;
      swap_pending <= 1'b0;
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < 8; r++)
          bank[b][r] <= 8'h00;
    end else begin
      row         <= row_n;
      d           <= d_n;
      frame_start <= boundary;
      swap_done   <= boundary && swap_pending;
      // A request arriving while one is pending is dropped, so each boundary swaps at most once.
      if (boundary && swap_pending) begin
        front_sel    <= ~front_sel;
        swap_pending <= 1'b0;
      end else if (swap_req) begin
        swap_pending <= 1'b1;
      end
      if (wr_valid && wr_ready)
        bank[~front_sel][wr_row] <= wr_data;
    end
  end

endmodule
